// File: rtl/rvvi_frame_buffer_pkg.sv
// Shared definitions for the RVVI store-and-forward frame buffer:
// buffer entry layout and the legal byte-strobe encodings.
package rvvi_frame_buffer_pkg;

    localparam int ENTRY_W = 37;

    localparam logic [3:0] STRB_1B = 4'b0001;
    localparam logic [3:0] STRB_2B = 4'b0011;
    localparam logic [3:0] STRB_3B = 4'b0111;
    localparam logic [3:0] STRB_4B = 4'b1111;

    typedef struct packed {
        logic        last;
        logic [3:0]  strb;
        logic [31:0] data;
    } frame_entry_t;

    // Index of the final valid byte in a word with a legal strobe.
    function automatic logic [1:0] last_lane(input logic [3:0] strb);
        case (strb)
            STRB_1B: return 2'd0;
            STRB_2B: return 2'd1;
            STRB_3B: return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/rvvi_frame_ram.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
module rvvi_frame_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port and registered read port; read data holds while rd_en is low.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/rvvi_frame_buffer.sv
// Store-and-forward buffer between the RVVI packetizer (32-bit words) and the
// MAC transmit port (bytes). A frame is released only once its last word has
// been written; a frame that alone fills the buffer is dropped whole.
module rvvi_frame_buffer
    import rvvi_frame_buffer_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  RvviAxiWdata,
    input  logic [3:0]                   RvviAxiWstrb,
    input  logic                         RvviAxiWlast,
    input  logic                         RvviAxiWvalid,
    output logic                         RvviAxiWready,
    output logic [7:0]                   TxTdata,
    output logic                         TxTvalid,
    output logic                         TxTlast,
    input  logic                         TxTready,
    output logic [$clog2(DEPTH_WORDS):0] PendingFrames,
    output logic [CNT_W-1:0]             DroppedFrames
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_WORDS);

    typedef enum logic {WR_ACCEPT, WR_DISCARD} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_t;

    wr_state_t    wr_state;
    rd_state_t    rd_state;
    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, used, wr_span;
    logic         full, wr_hs, wr_store, wr_commit;
    logic         rd_hs, last_byte, frame_done, rd_en, fetch_wait;
    logic [AW-1:0] rd_addr;
    logic [1:0]   byte_idx;
    frame_entry_t wr_entry, ram_q, word_q;

    assign used    = wr_ptr - rd_ptr;
    assign wr_span = wr_ptr - commit_ptr;
    assign full    = (used == DEPTH_P);

    assign RvviAxiWready = ~reset & ((wr_state == WR_DISCARD) | ~full);
    assign wr_hs     = RvviAxiWvalid & RvviAxiWready;
    assign wr_store  = wr_hs & (wr_state == WR_ACCEPT);
    assign wr_commit = wr_store & RvviAxiWlast;
    assign wr_entry  = '{last: RvviAxiWlast, strb: RvviAxiWstrb, data: RvviAxiWdata};

    assign TxTvalid   = (rd_state == RD_SEND);
    assign last_byte  = (byte_idx == last_lane(word_q.strb));
    assign TxTdata    = TxTvalid ? word_q.data[{byte_idx, 3'b000} +: 8] : 8'h00;
    assign TxTlast    = TxTvalid & last_byte & word_q.last;
    assign rd_hs      = TxTvalid & TxTready;
    assign frame_done = rd_hs & last_byte & word_q.last;

    // Reads start a committed frame from idle, or prefetch the next word of the
    // current frame on its final byte handshake (rd_ptr has not advanced yet).
    assign rd_en   = ((rd_state == RD_IDLE) & (PendingFrames != '0))
                   | (rd_hs & last_byte & ~word_q.last);
    assign rd_addr = (rd_state == RD_IDLE) ? rd_ptr[AW-1:0] : rd_ptr[AW-1:0] + AW'(1);

    rvvi_frame_ram #(.DEPTH(DEPTH_WORDS), .WIDTH(ENTRY_W)) u_ram (
        .clk     (clk),
        .wr_en   (wr_store),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Write FSM: store words, commit on last, drop a frame that fills the buffer alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state      <= WR_ACCEPT;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            DroppedFrames <= '0;
        end else begin
            case (wr_state)
                WR_ACCEPT: begin
                    if (wr_span == DEPTH_P) begin
                        // Buffer is full with this frame alone: rewind and discard the rest.
                        wr_ptr   <= commit_ptr;
                        wr_state <= WR_DISCARD;
                        if (DroppedFrames != {CNT_W{1'b1}})
                            DroppedFrames <= DroppedFrames + 1'b1;
                    end else if (wr_store) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (RvviAxiWlast) commit_ptr <= wr_ptr + 1'b1;
                    end
                end
                WR_DISCARD: begin
                    if (wr_hs & RvviAxiWlast) wr_state <= WR_ACCEPT;
                end
                default: wr_state <= WR_ACCEPT;
            endcase
        end
    end

    // Committed-frame count; a commit and a completion in one cycle cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PendingFrames <= '0;
        end else begin
            case ({wr_commit, frame_done})
                2'b10:   PendingFrames <= PendingFrames + 1'b1;
                2'b01:   PendingFrames <= PendingFrames - 1'b1;
                default: PendingFrames <= PendingFrames;
            endcase
        end
    end

    // Read FSM: fetch a word, then serialise its valid bytes little-endian.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state   <= RD_IDLE;
            rd_ptr     <= '0;
            word_q     <= '0;
            byte_idx   <= '0;
            fetch_wait <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (PendingFrames != '0) begin
                        rd_state   <= RD_FETCH;
                        fetch_wait <= 1'b0;
                    end
                end
                RD_FETCH: begin
                    // Mid-frame fetches idle one extra cycle so every inter-word
                    // gap is a fixed two cycles; RAM output holds meanwhile.
                    if (fetch_wait) begin
                        fetch_wait <= 1'b0;
                    end else begin
                        word_q   <= ram_q;
                        byte_idx <= '0;
                        rd_state <= RD_SEND;
                    end
                end
                RD_SEND: begin
                    if (rd_hs) begin
                        if (last_byte) begin
                            rd_ptr     <= rd_ptr + 1'b1;
                            rd_state   <= word_q.last ? RD_IDLE : RD_FETCH;
                            fetch_wait <= ~word_q.last;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvvi_frame_buffer.sv
// Directed bench for rvvi_frame_buffer: word frames in, byte stream out,
// compared against expected bytes built from the frame contents.
module tb_rvvi_frame_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] RvviAxiWdata;
    logic [3:0]  RvviAxiWstrb;
    logic        RvviAxiWlast, RvviAxiWvalid, RvviAxiWready;
    logic [7:0]  TxTdata;
    logic        TxTvalid, TxTlast, TxTready;
    logic [6:0]  PendingFrames;
    logic [15:0] DroppedFrames;

    always #5 clk = ~clk;

    rvvi_frame_buffer #(.DEPTH_WORDS(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RvviAxiWdata(RvviAxiWdata), .RvviAxiWstrb(RvviAxiWstrb),
        .RvviAxiWlast(RvviAxiWlast), .RvviAxiWvalid(RvviAxiWvalid),
        .RvviAxiWready(RvviAxiWready),
        .TxTdata(TxTdata), .TxTvalid(TxTvalid), .TxTlast(TxTlast), .TxTready(TxTready),
        .PendingFrames(PendingFrames), .DroppedFrames(DroppedFrames)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int words_acc = 0;
    int last_hs_cyc = 0;
    int first_valid_cyc = -1;
    logic [8:0] expq[$];
    logic [8:0] gotq[$];
    logic       prev_stall = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte monitor, sampled late in the low phase so inputs driven at the
    // falling edge are settled and outputs are those seen at the next rise.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (TxTvalid !== 1'b1 || TxTdata !== prev_data)
                    $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", TxTvalid, TxTdata, prev_data);
                else passed++;
            end
            if (TxTvalid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (TxTvalid && TxTready) gotq.push_back({TxTlast, TxTdata});
            prev_stall = TxTvalid && !TxTready;
            prev_data  = TxTdata;
            prev_valid = TxTvalid;
        end
    end

    task automatic send_word(input logic [31:0] d, input logic [3:0] s, input logic l, output bit ok);
        int waited = 0;
        @(negedge clk);
        RvviAxiWdata = d; RvviAxiWstrb = s; RvviAxiWlast = l; RvviAxiWvalid = 1'b1;
        #1;
        while (!RvviAxiWready && waited < 2000) begin
            @(negedge clk); #1; waited++;
        end
        ok = RvviAxiWready;
        if (ok) begin
            if (l) last_hs_cyc = cyc + 1;
            words_acc++;
            @(posedge clk);
            #1;
        end
        RvviAxiWvalid = 1'b0;
    endtask

    // Frame fid, nwords words; byte b of word w is fid*13 + w*4 + b.
    task automatic send_frame(input int fid, input int nwords, input logic [3:0] last_strb,
                              input bit expect_out, output bit ok);
        logic [31:0] d;
        logic [3:0]  s;
        int          lb;
        bit          okw;
        ok = 1'b1;
        for (int w = 0; w < nwords; w++) begin
            s = (w == nwords - 1) ? last_strb : 4'hF;
            for (int b = 0; b < 4; b++) d[8*b +: 8] = 8'(fid * 13 + w * 4 + b);
            lb = (s == 4'h1) ? 0 : (s == 4'h3) ? 1 : (s == 4'h7) ? 2 : 3;
            send_word(d, s, w == nwords - 1, okw);
            if (!okw) begin ok = 1'b0; break; end
            if (expect_out)
                for (int b = 0; b <= lb; b++)
                    expq.push_back({(w == nwords - 1) && (b == lb), d[8*b +: 8]});
        end
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int k = 0;
        while (gotq.size() < n && k < budget) begin @(negedge clk); k++; end
        ok = (gotq.size() >= n);
        repeat (10) @(negedge clk);
        #3;
    endtask

    function automatic int first_diff();
        if (gotq.size() != expq.size()) return -2;
        foreach (expq[i]) if (gotq[i] !== expq[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (RvviAxiWready !== 1'b0) $display("FAIL rst_wready: got %b need 0", RvviAxiWready); else passed++;
        checks++; if (TxTvalid !== 1'b0) $display("FAIL rst_tvalid: got %b need 0", TxTvalid); else passed++;
        checks++; if (TxTlast !== 1'b0) $display("FAIL rst_tlast: got %b need 0", TxTlast); else passed++;
        checks++; if (TxTdata !== 8'h00) $display("FAIL rst_tdata: got %h need 00", TxTdata); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL rst_pending: got %0d need 0", PendingFrames); else passed++;
        checks++; if (DroppedFrames !== 16'd0) $display("FAIL rst_dropped: got %0d need 0", DroppedFrames); else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        checks++; if (RvviAxiWready !== 1'b1) $display("FAIL post_rst_wready: got %b need 1", RvviAxiWready); else passed++;
    endtask

    task automatic test_single_frame();
        bit ok, okb;
        int lasts = 0;
        expq.delete(); gotq.delete();
        TxTready = 1'b1;
        first_valid_cyc = -1;
        send_frame(1, 23, 4'h3, 1'b1, ok);
        wait_bytes(90, 600, okb);
        foreach (gotq[i]) if (gotq[i][8]) lasts++;
        checks++; if (!ok || !okb) $display("FAIL single_timeout: sent=%b bytes=%0d need 90", ok, gotq.size()); else passed++;
        checks++; if (gotq.size() != 90) $display("FAIL single_count: got %0d need 90", gotq.size()); else passed++;
        checks++; if (first_diff() != -1) $display("FAIL single_stream: first diff %0d need -1", first_diff()); else passed++;
        checks++; if (gotq.size() == 90 && gotq[89][8] !== 1'b1) $display("FAIL single_tlast90: got %b need 1", gotq[89][8]); else passed++;
        checks++; if (lasts != 1) $display("FAIL single_nlast: got %0d need 1", lasts); else passed++;
        // Wlast handshake edge k -> first TxTvalid sampled in the cycle after edge k+2.
        checks++; if (first_valid_cyc - last_hs_cyc != 2) $display("FAIL single_latency: got %0d need 2", first_valid_cyc - last_hs_cyc); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL single_pending: got %0d need 0", PendingFrames); else passed++;
    endtask

    task automatic test_back_to_back();
        bit ok0, ok1, ok2, okb;
        expq.delete(); gotq.delete();
        TxTready = 1'b0;
        words_acc = 0;
        fork
            begin
                send_frame(10, 23, 4'hF, 1'b1, ok0);
                send_frame(11, 23, 4'hF, 1'b1, ok1);
                send_frame(12, 23, 4'hF, 1'b1, ok2);
            end
            begin
                repeat (120) @(negedge clk);
                #1;
                checks++; if (words_acc != 64) $display("FAIL b2b_words: got %0d need 64", words_acc); else passed++;
                checks++; if (RvviAxiWready !== 1'b0) $display("FAIL b2b_wready_full: got %b need 0", RvviAxiWready); else passed++;
                checks++; if (PendingFrames !== 7'd2) $display("FAIL b2b_pending: got %0d need 2", PendingFrames); else passed++;
                checks++; if (gotq.size() != 0) $display("FAIL b2b_no_bytes: got %0d need 0", gotq.size()); else passed++;
                TxTready = 1'b1;
            end
        join
        wait_bytes(276, 4000, okb);
        checks++; if (!(ok0 && ok1 && ok2 && okb)) $display("FAIL b2b_timeout: bytes=%0d need 276", gotq.size()); else passed++;
        checks++; if (first_diff() != -1) $display("FAIL b2b_stream: first diff %0d need -1", first_diff()); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL b2b_pending_end: got %0d need 0", PendingFrames); else passed++;
    endtask

    task automatic test_oversize_drop();
        bit ok, okb;
        expq.delete(); gotq.delete();
        TxTready = 1'b1;
        send_frame(20, 70, 4'hF, 1'b0, ok);
        repeat (20) @(negedge clk);
        #3;
        checks++; if (!ok) $display("FAIL drop_accept: all 70 words accepted=%b need 1", ok); else passed++;
        checks++; if (DroppedFrames !== 16'd1) $display("FAIL drop_count: got %0d need 1", DroppedFrames); else passed++;
        checks++; if (gotq.size() != 0 || first_valid_cyc < 0) $display("FAIL drop_no_output: got %0d bytes need 0", gotq.size()); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL drop_pending: got %0d need 0", PendingFrames); else passed++;
        send_frame(21, 23, 4'h7, 1'b1, ok);
        wait_bytes(91, 600, okb);
        checks++; if (first_diff() != -1 || !okb) $display("FAIL drop_next_frame: first diff %0d need -1", first_diff()); else passed++;
    endtask

    task automatic test_random_stall();
        bit done = 1'b0;
        bit okall = 1'b1;
        bit okb;
        logic [3:0] strbs [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
        expq.delete(); gotq.delete();
        void'($urandom(32'd1234));
        fork
            begin
                bit ok;
                for (int f = 0; f < 20; f++) begin
                    send_frame(50 + f, 1 + (f * 7) % 13, strbs[f % 4], 1'b1, ok);
                    okall &= ok;
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    TxTready = 1'($urandom_range(0, 1));
                end
            end
        join
        TxTready = 1'b1;
        wait_bytes(expq.size(), 6000, okb);
        checks++; if (!okall || !okb) $display("FAIL rand_timeout: bytes=%0d need %0d", gotq.size(), expq.size()); else passed++;
        checks++; if (first_diff() != -1) $display("FAIL rand_stream: first diff %0d need -1", first_diff()); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL rand_pending: got %0d need 0", PendingFrames); else passed++;
    endtask

    task automatic test_commit_collision();
        bit ok, okb;
        int k = 0;
        logic [31:0] d2 = 32'hA1B2C3D4;
        expq.delete(); gotq.delete();
        TxTready = 1'b0;
        send_frame(30, 1, 4'h1, 1'b1, ok);
        while (!TxTvalid && k < 50) begin @(negedge clk); #1; k++; end
        checks++; if (TxTvalid !== 1'b1 || PendingFrames !== 7'd1) $display("FAIL coll_pre: valid=%b pending=%0d need 1/1", TxTvalid, PendingFrames); else passed++;
        // Frame-1 last byte handshake and frame-2 commit land on the same edge.
        @(negedge clk);
        TxTready = 1'b1;
        RvviAxiWdata = d2; RvviAxiWstrb = 4'h3; RvviAxiWlast = 1'b1; RvviAxiWvalid = 1'b1;
        expq.push_back({1'b0, d2[7:0]});
        expq.push_back({1'b1, d2[15:8]});
        #1;
        checks++; if (RvviAxiWready !== 1'b1) $display("FAIL coll_wready: got %b need 1", RvviAxiWready); else passed++;
        @(posedge clk); #1;
        RvviAxiWvalid = 1'b0;
        @(negedge clk); #3;
        checks++; if (PendingFrames !== 7'd1) $display("FAIL coll_pending: got %0d need 1", PendingFrames); else passed++;
        checks++; if (gotq.size() != 1) $display("FAIL coll_first_byte: got %0d bytes need 1", gotq.size()); else passed++;
        wait_bytes(3, 100, okb);
        checks++; if (first_diff() != -1 || !ok || !okb) $display("FAIL coll_stream: first diff %0d need -1", first_diff()); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL coll_pending_end: got %0d need 0", PendingFrames); else passed++;
    endtask

    task automatic test_reset_mid_tx();
        bit ok, okb;
        int lasts = 0;
        expq.delete(); gotq.delete();
        TxTready = 1'b1;
        send_frame(40, 23, 4'hF, 1'b0, ok);
        wait_bytes(10, 200, okb);
        @(negedge clk);
        reset = 1'b1;
        #1;
        foreach (gotq[i]) if (gotq[i][8]) lasts++;
        checks++; if (TxTvalid !== 1'b0 || TxTlast !== 1'b0) $display("FAIL midrst_tx: valid=%b last=%b need 0/0", TxTvalid, TxTlast); else passed++;
        checks++; if (PendingFrames !== 7'd0) $display("FAIL midrst_pending: got %0d need 0", PendingFrames); else passed++;
        checks++; if (DroppedFrames !== 16'd0) $display("FAIL midrst_dropped: got %0d need 0", DroppedFrames); else passed++;
        checks++; if (lasts != 0 || !okb) $display("FAIL midrst_partial: lasts=%0d bytes=%0d need 0 lasts", lasts, gotq.size()); else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        gotq.delete();
        repeat (10) @(negedge clk);
        #3;
        checks++; if (gotq.size() != 0 || TxTvalid !== 1'b0) $display("FAIL midrst_empty: bytes=%0d valid=%b need 0/0", gotq.size(), TxTvalid); else passed++;
        send_frame(41, 23, 4'h1, 1'b1, ok);
        wait_bytes(89, 600, okb);
        checks++; if (first_diff() != -1 || !ok || !okb) $display("FAIL midrst_next_frame: first diff %0d need -1", first_diff()); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        RvviAxiWdata = '0; RvviAxiWstrb = '0; RvviAxiWlast = 1'b0; RvviAxiWvalid = 1'b0;
        TxTready = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_oversize_drop();
        test_random_stall();
        test_commit_collision();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
